// File: rtl/demux_1to4_reg_pkg.sv
// Shared constants, slot state encoding and helpers for the registered 1-to-4 demultiplexer.
package demux_1to4_reg_pkg;

  localparam int unsigned DMX_NCH   = 4;
  localparam int unsigned DMX_SELW  = 2;
  localparam int unsigned DMX_CNTW  = 8;
  localparam int unsigned DMX_WIDTH = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef logic [DMX_CNTW-1:0] drop_cnt_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == '1) ? v : v + drop_cnt_t'(1);
  endfunction

endpackage

// File: rtl/demux_1to4_reg_if.sv
// Producer/consumer bus of the 1-to-4 demux: one input stream, four output channels, stall counter.
interface demux_1to4_reg_if
  import demux_1to4_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DMX_WIDTH
);

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic [DMX_SELW-1:0] Select;
  logic [DMX_NCH-1:0]  out_valid;
  logic [DMX_NCH-1:0]  out_ready;
  logic [WIDTH-1:0]    out_data0;
  logic [WIDTH-1:0]    out_data1;
  logic [WIDTH-1:0]    out_data2;
  logic [WIDTH-1:0]    out_data3;
  logic [DMX_CNTW-1:0] drop_cnt;

  modport master (
    output in_valid, in_data, Select, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, Select, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, drop_cnt
  );

endinterface

// File: rtl/demux_1to4_reg_slot.sv
// One-entry channel buffer: full flag FSM plus data register, loaded on push, released on pop.
module demux_1to4_reg_slot
  import demux_1to4_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DMX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data only moves on push, so it stays stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_push) begin
      r_data <= i_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_push)            w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (i_pop && !i_push)  w_state_nxt = SLOT_EMPTY;
      default:                           w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    o_full = (r_state == SLOT_FULL);
    o_data = r_data;
  end

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into one of four single-word channel buffers.
module demux_1to4_reg
  import demux_1to4_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DMX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_1to4_reg_if.slave  bus
);

  logic [DMX_NCH-1:0] w_sel_oh;
  logic [DMX_NCH-1:0] w_full;
  logic [DMX_NCH-1:0] w_push;
  logic [DMX_NCH-1:0] w_pop;
  logic               w_in_ready;
  logic [WIDTH-1:0]   w_data [DMX_NCH];
  drop_cnt_t          r_drop_cnt;

  // An unknown Select falls to default: no channel selected, so no push and in_ready=0.
  always_comb begin
    w_sel_oh = '0;
    case (bus.Select)
      2'd0:    w_sel_oh = 4'b0001;
      2'd1:    w_sel_oh = 4'b0010;
      2'd2:    w_sel_oh = 4'b0100;
      2'd3:    w_sel_oh = 4'b1000;
      default: w_sel_oh = '0;
    endcase
  end

  always_comb begin
    w_pop      = w_full & bus.out_ready;
    w_in_ready = |(w_sel_oh & (~w_full | bus.out_ready));
    w_push     = w_sel_oh & {DMX_NCH{bus.in_valid & w_in_ready}};
  end

  for (genvar g = 0; g < DMX_NCH; g++) begin : g_slot
    demux_1to4_reg_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push[g]),
      .i_pop  (w_pop[g]),
      .i_data (bus.in_data),
      .o_full (w_full[g]),
      .o_data (w_data[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (bus.in_valid && !w_in_ready) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = w_full;
    bus.out_data0 = w_data[0];
    bus.out_data1 = w_data[1];
    bus.out_data2 = w_data[2];
    bus.out_data3 = w_data[3];
    bus.drop_cnt  = r_drop_cnt;
  end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Scoreboard bench for demux_1to4_reg: per-channel expected-word queues filled on accept, drained on pop.
module tb_demux_1to4_reg;

  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [15:0] sb [4][$];
  logic [7:0]  m_drop;

  demux_1to4_reg_if #(.WIDTH(16)) bus ();

  demux_1to4_reg #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] dout(input int ch);
    case (ch)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  // Inputs are already driven; compare outputs mid-cycle, update the model, advance one edge.
  task automatic step();
    logic exp_rdy;
    #2;
    exp_rdy = 1'b0;
    if (!$isunknown(bus.Select))
      exp_rdy = (sb[bus.Select].size() == 0) || bus.out_ready[bus.Select];
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    check("drop_cnt", {24'd0, bus.drop_cnt}, {24'd0, m_drop});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out_valid%0d", i), {31'd0, bus.out_valid[i]}, {31'd0, sb[i].size() != 0});
      if (sb[i].size() != 0) begin
        check($sformatf("out_data%0d", i), {16'd0, dout(i)}, {16'd0, sb[i][0]});
        if (bus.out_ready[i]) void'(sb[i].pop_front());
      end
    end
    if (bus.in_valid && exp_rdy) sb[bus.Select].push_back(bus.in_data);
    if (bus.in_valid && !exp_rdy && m_drop != 8'hFF) m_drop++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [15:0] d, input logic [3:0] ordy);
    bus.in_valid  = v;
    bus.Select    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic check_zero_data(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_data%0d", tag, i), {16'd0, dout(i)}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_drop   = 8'd0;
    rst_n    = 1'b0;
    drive(1'b0, 2'd0, 16'd0, 4'b0000);

    // Reset state, then idle after release.
    #3;
    check("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("rst_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
    check_zero_data("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_zero_data("idle");

    // Single push to channel 2, held with consumer stalled.
    drive(1'b1, 2'd2, 16'hA5A5, 4'b0000);
    step();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("push2_out_valid", {28'd0, bus.out_valid}, 32'h4);
    check("push2_data", {16'd0, bus.out_data2}, 32'hA5A5);
    for (int i = 0; i < 5; i++) step();

    // Full channel 2 blocks only its own traffic; channel 1 still accepts.
    drive(1'b1, 2'd2, 16'h1111, 4'b0000);
    for (int i = 0; i < 3; i++) step();
    drive(1'b1, 2'd1, 16'h2222, 4'b0000);
    step();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("ch1_accept_out_valid", {28'd0, bus.out_valid}, 32'h6);
    step();

    // Same-cycle pop and refill on channel 0.
    drive(1'b1, 2'd0, 16'h0BEE, 4'b0000);
    step();
    drive(1'b1, 2'd0, 16'h1234, 4'b0001);
    step();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("refill_data0", {16'd0, bus.out_data0}, 32'h1234);
    check("refill_valid0", {31'd0, bus.out_valid[0]}, 32'd1);
    step();

    // Long stall on full channel 2: counter must saturate.
    drive(1'b1, 2'd2, 16'h5555, 4'b0000);
    for (int i = 0; i < 300; i++) step();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("drop_sat", {24'd0, bus.drop_cnt}, 32'hFF);
    step();

    // Back-to-back streaming into channel 3 with consumer always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd3, 16'h3000 + 16'(i), 4'b1000);
      step();
    end
    drive(1'b0, 2'd0, 16'h0000, 4'b1000);
    step();

    // Build out_valid=1011, then asynchronous reset between edges.
    drive(1'b0, 2'd0, 16'h0000, 4'b0100);
    step();
    drive(1'b1, 2'd3, 16'h3333, 4'b0000);
    step();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("pre_rst_out_valid", {28'd0, bus.out_valid}, 32'hB);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("async_rst_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
    check_zero_data("async_rst");
    for (int i = 0; i < 4; i++) sb[i].delete();
    m_drop = 8'd0;
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2'd1, 16'h7777, 4'b0000);
    step();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("post_rst_data1", {16'd0, bus.out_data1}, 32'h7777);
    step();

    // Unknown Select: no acceptance, counted as a stall.
    bus.in_valid = 1'b1;
    bus.Select   = 2'bxx;
    step();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    step();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            16'($urandom), 4'($urandom));
      step();
    end
    drive(1'b0, 2'd0, 16'h0000, 4'b1111);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
